dmem_arbiter: RTL

- Two-requester round-robin arbiter and sequencer in front of Data_Memory (1024 x 16 data memory).
- Requester 0 is the load/store unit; requester 1 is the debug/DMA loader.
- Serialises accesses, drives the memory control and address lines, and returns read data and completion to the winning requester.
- Rejects out-of-range addresses without touching memory.

---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/rr_pick2.sv | 20 ++
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants and FSM state encoding for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: on contention the port that did
// not win last time is chosen.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of a 1024 x 16 data
// memory; one access per three cycles, out-of-range addresses never reach memory.
//
//   state  | meaning
//   IDLE   | waiting for a request; winner captured at the edge leaving IDLE
//   ACCESS | memory control lines driven; memory acts at the edge ending it
//   RESP   | winner's ack/err pulse; read data passed through from memory
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int P_DATA_W = DATA_W,
    parameter int P_ADDR_W = ADDR_W,
    parameter int P_DEPTH  = DEPTH
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req0,
    input  logic                we0,
    input  logic [P_ADDR_W-1:0] addr0,
    input  logic [P_DATA_W-1:0] wdata0,
    output logic                ack0,
    output logic                err0,
    output logic [P_DATA_W-1:0] rdata0,
    input  logic                req1,
    input  logic                we1,
    input  logic [P_ADDR_W-1:0] addr1,
    input  logic [P_DATA_W-1:0] wdata1,
    output logic                ack1,
    output logic                err1,
    output logic [P_DATA_W-1:0] rdata1,
    output logic [P_ADDR_W-1:0] mem_addr,
    output logic [P_DATA_W-1:0] mem_wdata,
    output logic                mem_write,
    output logic                mem_read,
    input  logic [P_DATA_W-1:0] mem_rdata,
    output logic                busy
);

    localparam logic [P_ADDR_W-1:0] LP_DEPTH = P_ADDR_W'(P_DEPTH);

    arb_state_t            r_state;
    arb_state_t            w_next_state;
    logic                  r_last_grant;
    logic                  r_id;
    logic                  r_in_range;
    logic                  r_rd_ok;
    logic [P_ADDR_W-1:0]   r_mem_addr;
    logic [P_DATA_W-1:0]   r_mem_wdata;
    logic                  r_mem_write;
    logic                  r_mem_read;
    logic                  r_ack0;
    logic                  r_ack1;
    logic                  r_err0;
    logic                  r_err1;

    logic                  w_grant_valid;
    logic                  w_grant_id;
    logic                  w_sel_we;
    logic [P_ADDR_W-1:0]   w_sel_addr;
    logic [P_DATA_W-1:0]   w_sel_wdata;
    logic                  w_sel_in_range;

    rr_pick2 u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (r_last_grant),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    // Full-width compare so that high address bits can never alias into range.
    always_comb begin
        w_sel_we       = w_grant_id ? we1    : we0;
        w_sel_addr     = w_grant_id ? addr1  : addr0;
        w_sel_wdata    = w_grant_id ? wdata1 : wdata0;
        w_sel_in_range = (w_sel_addr < LP_DEPTH);
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_grant_valid) w_next_state = ACCESS;
            ACCESS:  w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_in_range   <= 1'b0;
            r_rd_ok      <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_id         <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_in_range   <= w_sel_in_range;
                        r_rd_ok      <= ~w_sel_we & w_sel_in_range;
                        r_mem_addr   <= w_sel_addr;
                        r_mem_wdata  <= w_sel_wdata;
                        r_mem_write  <= w_sel_we & w_sel_in_range;
                        r_mem_read   <= ~w_sel_we & w_sel_in_range;
                    end
                end
                ACCESS: begin
                    r_mem_write <= 1'b0;
                    r_mem_read  <= 1'b0;
                    r_ack0      <= ~r_id;
                    r_ack1      <= r_id;
                    r_err0      <= ~r_id & ~r_in_range;
                    r_err1      <= r_id & ~r_in_range;
                end
                default: begin
                    r_ack0 <= 1'b0;
                    r_ack1 <= 1'b0;
                    r_err0 <= 1'b0;
                    r_err1 <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_write = r_mem_write;
    assign mem_read  = r_mem_read;
    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign err0      = r_err0;
    assign err1      = r_err1;
    assign rdata0    = (r_ack0 && r_rd_ok) ? mem_rdata : '0;
    assign rdata1    = (r_ack1 && r_rd_ok) ? mem_rdata : '0;
    assign busy      = (r_state != IDLE);

endmodule
